encoder_event_fifo: RTL

- Downstream stage of the 8-to-3 encoder. Consumes its 3-bit code and Valid flag.
- Detects new encode events and buffers the captured codes in a small FIFO.
- Presents the codes to a consumer over a valid/ready handshake.
- Provides event counting and a sticky overflow flag so that no lost event goes unnoticed.

---
 rtl/encoder_event_fifo.sv | 88 ++++++++
 1 files changed

// File: rtl/encoder_event_fifo.sv
// Captures encoder events (new Valid rise or code change) into a show-ahead FIFO.
// One-cycle push-to-output latency, no bypass; events arriving while full are dropped and flagged.
module encoder_event_fifo #(
  parameter int CODE_W = 3,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] In,
  input  logic              Valid,
  output logic [CODE_W-1:0] Out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW:0]       count,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [CODE_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              last_valid_q, last_valid_d;
  logic [CODE_W-1:0] last_code_q, last_code_d;

  logic evt, pop, push, drop;

  always_comb begin
    evt  = Valid & (~last_valid_q | (In != last_code_q));
    pop  = (count_q != '0) & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push = evt & ((count_q != FULL_CNT) | pop);
    drop = evt & ~push;

    last_valid_d = Valid;
    last_code_d  = In;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    mem_d        = mem_q;

    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push) begin
      mem_d[wr_ptr_q] = In;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);

    if (clr_ovf) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      last_valid_q <= 1'b0;
      last_code_q  <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      last_valid_q <= last_valid_d;
      last_code_q  <= last_code_d;
    end
  end

  // Storage is not reset; only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign Out       = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule
